trivium_ctrl: RTL

TRIVIUM_CTRL -- requirements
Module: trivium_ctrl

---
 rtl/trivium_pkg.sv | 17 +
 rtl/trivium_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/trivium_pkg.sv
// Shared constants and FSM state encoding for the Trivium keystream controller.
package trivium_pkg;

  localparam int KEY_W          = 80;
  localparam int IV_W           = 80;
  localparam int WARMUP_DEFAULT = 1152;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WARMUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_HOLD   = 3'd4,
    ST_FLUSH  = 3'd5
  } state_t;

endpackage

// File: rtl/trivium_ctrl.sv
// Sequencer for an external Trivium core: load, warm-up, byte packing and output handshake.
// Define TRIVIUM_CTRL_XOR_EN to add pt_data and emit keystream XOR plaintext.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | core_init strobe, key/iv loaded into core
// WARMUP | core stepped WARMUP_CYCLES times, output discarded
// RUN    | core stepped, bits packed MSB-first into bytes
// HOLD   | byte complete but output slot occupied; core paused
// FLUSH  | last byte presented, waiting for its transfer
module trivium_ctrl
  import trivium_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  input  logic [15:0]      len,
  output logic             core_init,
  output logic             core_enable,
  input  logic             core_ks_bit,
  output logic [7:0]       ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy,
  output logic             done
`ifdef TRIVIUM_CTRL_XOR_EN
  ,
  input  logic [7:0]       pt_data
`endif
);

  localparam int WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  state_t          state;
  logic [WU_W-1:0] wu_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      packer;
  logic [15:0]     len_q;
  logic [15:0]     byte_cnt;

  logic [7:0]      next_byte;
  logic [7:0]      load_src;
  logic [7:0]      byte_out;
  logic            slot_free;
  logic            last_byte;

  // key/iv go straight to the core beside us; the controller only carries them through
  logic            unused_key_iv;
  assign unused_key_iv = ^{key, iv};

  assign next_byte = {packer[6:0], core_ks_bit};
  assign load_src  = (state == ST_HOLD) ? packer : next_byte;
  assign slot_free = !ks_valid || ks_ready;
  assign last_byte = (len_q != 16'd0) && ((byte_cnt + 16'd1) == len_q);

`ifdef TRIVIUM_CTRL_XOR_EN
  assign byte_out = load_src ^ pt_data;
`else
  assign byte_out = load_src;
`endif

  assign core_init   = (state == ST_LOAD);
  assign core_enable = (state == ST_WARMUP) || (state == ST_RUN);
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wu_cnt   <= '0;
      bit_cnt  <= 3'd0;
      packer   <= 8'h00;
      len_q    <= 16'd0;
      byte_cnt <= 16'd0;
      ks_data  <= 8'h00;
      ks_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // any byte in flight is dropped and never shown
        state    <= ST_IDLE;
        ks_valid <= 1'b0;
        ks_data  <= 8'h00;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state    <= ST_LOAD;
              len_q    <= len;
              bit_cnt  <= 3'd0;
              byte_cnt <= 16'd0;
            end
          end
          ST_LOAD: begin
            wu_cnt <= WU_W'(WARMUP_CYCLES - 1);
            state  <= ST_WARMUP;
          end
          ST_WARMUP: begin
            if (wu_cnt == '0) state <= ST_RUN;
            else              wu_cnt <= wu_cnt - 1'b1;
          end
          ST_RUN: begin
            packer  <= next_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (ks_valid && ks_ready) ks_valid <= 1'b0;
            if (bit_cnt == 3'd7) begin
              if (slot_free) begin
                ks_data  <= byte_out;
                ks_valid <= 1'b1;
                byte_cnt <= byte_cnt + 16'd1;
                if (last_byte) state <= ST_FLUSH;
              end else begin
                state <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (ks_ready) begin
              ks_data  <= byte_out;
              ks_valid <= 1'b1;
              byte_cnt <= byte_cnt + 16'd1;
              state    <= last_byte ? ST_FLUSH : ST_RUN;
            end
          end
          ST_FLUSH: begin
            if (ks_ready || !ks_valid) begin
              ks_valid <= 1'b0;
              done     <= 1'b1;
              state    <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
